// File: rtl/sa_pkg.sv
// sa_pkg: direction bit indices, input indices and legal-direction check for the sa_02 switch allocator
package sa_pkg;
  localparam int DIR_W = 0;
  localparam int DIR_S = 1;
  localparam int DIR_L = 2;
  localparam int DIR_RSV = 3;
  localparam int IN_W = 0;
  localparam int IN_S = 1;
  localparam int IN_L = 2;
  function automatic logic dir_legal(input logic [3:0] d);
    return !d[DIR_RSV] && (d[2:0] == 3'b001 || d[2:0] == 3'b010 || d[2:0] == 3'b100);
  endfunction
endpackage

// File: rtl/sa_02_outport.sv
// sa_02_outport: round-robin arbiter, credit counter and output register for one output link
// SA02_STATS_EN adds saturating grant and stall counters
module sa_02_outport import sa_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3,
  parameter int DATASIZE = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               cand,
  input  logic [2:0][DATASIZE-1:0] data_in,
  input  logic                     credit_in,
  output logic [2:0]               grant,
  output logic [DATASIZE-1:0]      data_out,
  output logic                     valid_out,
  output logic [WIDTH:0]           credit_out,
  output logic                     ovf
`ifdef SA02_STATS_EN
  ,
  output logic [15:0]              grant_cnt,
  output logic [15:0]              stall_cnt
`endif
);
  localparam logic [WIDTH:0] FULL = (WIDTH+1)'(DEPTH);
  logic [1:0] ptr, win, idx;
  logic hit;
  logic [2:0] cand_ok;
  assign cand_ok = credit_out != '0 ? cand : 3'b000;
  // scan from the farthest slot back so the first candidate at/after ptr wins
  always_comb begin
    win = ptr;
    hit = 1'b0;
    idx = '0;
    for (int k = 2; k >= 0; k--) begin
      idx = 2'(({1'b0, ptr} + 3'(k)) % 3'd3);
      if (cand_ok[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end
  assign grant = hit ? 3'b001 << win : 3'b000;
  assign ovf = credit_in && !hit && credit_out == FULL;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      credit_out <= FULL;
      valid_out <= 1'b0;
      data_out <= '0;
    end else begin
      valid_out <= hit;
      if (hit) begin
        data_out <= data_in[win];
        ptr <= win == 2'(IN_L) ? 2'(IN_W) : win + 2'd1;
      end
      if (hit && !credit_in) credit_out <= credit_out - 1'b1;
      else if (!hit && credit_in && credit_out != FULL) credit_out <= credit_out + 1'b1;
    end
`ifdef SA02_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (hit && grant_cnt != '1) grant_cnt <= grant_cnt + 1'b1;
      if (cand != '0 && credit_out == '0 && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
`endif
endmodule

// File: rtl/sa_02.sv
// sa_02: switch allocator / output scheduler for router node 02 (W, S, L inputs to W, S, L outputs)
// SA02_STATS_EN exports per-output grant and stall counters
module sa_02 import sa_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3,
  parameter int DATASIZE = 40
) (
  input  logic                sa_clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] W_data_in,
  input  logic [DATASIZE-1:0] S_data_in,
  input  logic [DATASIZE-1:0] L_data_in,
  input  logic [3:0]          W_dir_in,
  input  logic [3:0]          S_dir_in,
  input  logic [3:0]          L_dir_in,
  input  logic                W_req,
  input  logic                S_req,
  input  logic                L_req,
  output logic                W_ack,
  output logic                S_ack,
  output logic                L_ack,
  output logic [DATASIZE-1:0] W_data_out,
  output logic [DATASIZE-1:0] S_data_out,
  output logic [DATASIZE-1:0] L_data_out,
  output logic                W_valid_out,
  output logic                S_valid_out,
  output logic                L_valid_out,
  input  logic                W_credit_in,
  input  logic                S_credit_in,
  input  logic                L_credit_in,
  output logic [WIDTH:0]      W_credit_out,
  output logic [WIDTH:0]      S_credit_out,
  output logic [WIDTH:0]      L_credit_out,
`ifdef SA02_STATS_EN
  output logic [15:0]         W_grant_cnt,
  output logic [15:0]         S_grant_cnt,
  output logic [15:0]         L_grant_cnt,
  output logic [15:0]         W_stall_cnt,
  output logic [15:0]         S_stall_cnt,
  output logic [15:0]         L_stall_cnt,
`endif
  output logic                dir_err
);
  logic [2:0][DATASIZE-1:0] din, dout;
  logic [2:0][3:0] dir;
  logic [2:0][2:0] cand, grant;
  logic [2:0][WIDTH:0] cout;
  logic [2:0] req, legal, illegal, ack, vout, cin, ovf;
  assign din = {L_data_in, S_data_in, W_data_in};
  assign dir = {L_dir_in, S_dir_in, W_dir_in};
  assign req = {L_req, S_req, W_req};
  assign cin = {L_credit_in, S_credit_in, W_credit_in};
  assign {L_ack, S_ack, W_ack} = ack;
  assign {L_valid_out, S_valid_out, W_valid_out} = vout;
  assign {L_data_out, S_data_out, W_data_out} = dout;
  assign {L_credit_out, S_credit_out, W_credit_out} = cout;
  // an illegal request is acked so the channel drains, but never reaches an arbiter
  for (genvar i = 0; i < 3; i++) begin : g_in
    assign legal[i] = req[i] && dir_legal(dir[i]);
    assign illegal[i] = req[i] && !dir_legal(dir[i]);
    assign ack[i] = grant[0][i] | grant[1][i] | grant[2][i] | illegal[i];
    for (genvar o = 0; o < 3; o++) begin : g_cand
      assign cand[o][i] = legal[i] && dir[i][o];
    end
  end
`ifdef SA02_STATS_EN
  logic [2:0][15:0] gcnt, scnt;
  assign {L_grant_cnt, S_grant_cnt, W_grant_cnt} = gcnt;
  assign {L_stall_cnt, S_stall_cnt, W_stall_cnt} = scnt;
`endif
  for (genvar o = 0; o < 3; o++) begin : g_out
    sa_02_outport #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DATASIZE)) u_port (
      .clk(sa_clk),
      .rst(rst),
      .cand(cand[o]),
      .data_in(din),
      .credit_in(cin[o]),
      .grant(grant[o]),
      .data_out(dout[o]),
      .valid_out(vout[o]),
      .credit_out(cout[o]),
`ifdef SA02_STATS_EN
      .grant_cnt(gcnt[o]),
      .stall_cnt(scnt[o]),
`endif
      .ovf(ovf[o])
    );
  end
  always_ff @(posedge sa_clk or posedge rst)
    if (rst) dir_err <= 1'b0;
    else if (|illegal || |ovf) dir_err <= 1'b1;
endmodule

// File: doc/sa_02.md
Name: sa_02

Overview:
- Switch allocator and output scheduler for router node 02.
- Sits between the three route-compute channels (W, S, L inputs) and the node's three output links (W, S, L).
- Each cycle, per output port: round-robin arbitration among requesting inputs, gated by a credit counter that mirrors the downstream input FIFO.
- Registers the winning flit onto the output link and acks the winning input.

Parameters:
- DEPTH, 8: downstream FIFO depth; initial and maximum credit per output.
- WIDTH, 3: credit counter width is WIDTH+1 bits (must hold DEPTH).
- DATASIZE, 40: flit width.

Ports:
- sa_clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- W_data_in / S_data_in / L_data_in  in  DATASIZE each  flit from route-compute channel
- W_dir_in / S_dir_in / L_dir_in  in  4 each  one-hot direction: bit0=W out, bit1=S out, bit2=L out, bit3 reserved
- W_req / S_req / L_req  in  1 each  input holds a flit with valid direction
- W_ack / S_ack / L_ack  out  1 each  flit consumed this cycle (drives rc_ready_*)
- W_data_out / S_data_out / L_data_out  out  DATASIZE each  registered output flit
- W_valid_out / S_valid_out / L_valid_out  out  1 each  output flit valid
- W_credit_in / S_credit_in / L_credit_in  in  1 each  one downstream slot freed
- W_credit_out / S_credit_out / L_credit_out  out  WIDTH+1 each  current credit count (pressure export)
- dir_err  out  1  sticky: illegal direction seen

Behaviour:
- Reset: all *_valid_out=0, *_data_out=0, all acks=0, credits=DEPTH, RR pointers=0 (W highest priority), dir_err=0. Reset mid-packet discards in-flight output and restores credits.
- Legal direction: exactly one of bits[2:0] set and bit3=0. An input targets only one output, so inputs never compete across outputs.
- Per output o, each cycle:
  - Candidates = inputs with req=1 and legal dir selecting o.
  - If credit_o>0 and any candidate exists, grant the first candidate at or after ptr_o in order W(0), S(1), L(2), wrapping.
  - If no grant, ptr_o holds.
- Grant effects:
  - ack of winner is combinational, same cycle.
  - Next edge: data_out_o<=winner data, valid_out_o<=1, ptr_o<=(winner+1) mod 3.
  - Latency is 1 cycle from req to valid_out.
- No grant: valid_out_o<=0 next edge; data_out_o holds its last value.
- Credit counter per output:
  - grant only: -1; credit_in only: +1; both in same cycle: unchanged.
  - credit=0: no grant, even with requests (full-stall).
  - credit_in at DEPTH: saturates at DEPTH and sets dir_err (overflow is illegal).
- Illegal direction with req=1: input is acked the same cycle, flit dropped (never output), dir_err set; dir_err is cleared only by rst.
- Losers keep req asserted. Round-robin guarantees service within 3 grants of their output.

Optional Feature:
- Macro SA02_STATS_EN.
- Defined: adds per-output 16-bit saturating grant counters and stall counters (cycles with candidates but credit=0), exported as W/S/L_grant_cnt and W/S/L_stall_cnt outputs; all reset to 0; no rollover past 16'hFFFF.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Shared package sa_pkg:
  - direction bit indices DIR_W=0, DIR_S=1, DIR_L=2, DIR_RSV=3;
  - input index constants IN_W/IN_S/IN_L;
  - a legal-direction check function.
- One sub-module, sa_02_outport: round-robin arbiter, pointer, credit counter and output register for one output; instantiated three times.
- Top level handles direction decode, ack OR-ing and dir_err.

Test Plan:
- Reset then single W_req, dir=4'b0010, data=40'hA5 -> W_ack=1 same cycle; next cycle S_valid_out=1, S_data_out=40'hA5; S_credit_out 8->7.
- W, S, L all req to L output every cycle for 6 cycles, credits ample -> L_data_out winner order W,S,L,W,S,L; each input acked twice.
- 8 flits to W output with no credit_in -> W_credit_out reaches 0; 9th req not acked; one W_credit_in pulse -> acked next cycle.
- Grant and W_credit_in in same cycle at credit=5 -> stays 5.
- L_req with dir=4'b0011, then dir=4'b1000 -> L_ack=1 each time; no valid_out on any port; dir_err=1 until rst.
- Assert rst mid-stream with valid_out=1, credit=3 -> all valid_out=0, credits=8, pointers reset; first post-reset contention goes to W.
